shift_right_sticky_align: RTL

SHIFT_RIGHT_STICKY_ALIGN -- requirements
Module: shift_right_sticky_align

---
 rtl/shift_right_sticky_align_pkg.sv | 23 ++
 rtl/shift_right_sticky_align_shift_stage.sv | 17 +
 rtl/shift_right_sticky_align.sv | 97 +++++++++
 3 files changed

// File: rtl/shift_right_sticky_align_pkg.sv
// Shared FPU constants and the stage-1 pipeline record for the mantissa
// alignment shifter.
package shift_right_sticky_align_pkg;

    localparam int MANT_W    = 24;
    localparam int GRS_W     = 3;
    localparam int WORK_W    = MANT_W + GRS_W;
    localparam int SHIFT_SAT = 27;

    // State carried from stage 1 to stage 2.
    typedef struct packed {
        logic [WORK_W-1:0] w;       // value after the 16/8 shifts
        logic              sticky;  // OR of bits dropped so far
        logic [2:0]        s_lo;    // remaining shift: 4, 2, 1
        logic              sat;     // shift saturated at SHIFT_SAT
    } stage1_t;

    // Any shift of SHIFT_SAT or more behaves as exactly SHIFT_SAT.
    function automatic logic [4:0] clamp_shift(input logic [7:0] sa);
        return (sa >= 8'(SHIFT_SAT)) ? 5'(SHIFT_SAT) : sa[4:0];
    endfunction

endpackage

// File: rtl/shift_right_sticky_align_shift_stage.sv
// Combinational right shift by a fixed power of two; also reports whether
// any set bit was shifted out.
module shift_stage_sticky
    import shift_right_sticky_align_pkg::*;
#(
    parameter int SHIFT = 1
) (
    input  logic [WORK_W-1:0] din_i,
    input  logic              en_i,
    output logic [WORK_W-1:0] dout_o,
    output logic              sticky_o
);

    assign dout_o   = en_i ? (din_i >> SHIFT) : din_i;
    assign sticky_o = en_i & (|din_i[SHIFT-1:0]);

endmodule

// File: rtl/shift_right_sticky_align.sv
// Two-stage mantissa alignment shifter with guard/round/sticky output and
// a valid/ready handshake that stalls as one unit.
module shift_right_sticky_align
    import shift_right_sticky_align_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] a,
    input  logic [7:0]        sa,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] b,
    output logic [GRS_W-1:0]  grs
);

    logic              valid1_q;
    stage1_t           s1_q, s1_d;
    logic              valid2_q;
    logic [MANT_W-1:0] b_q, b_d;
    logic [GRS_W-1:0]  grs_q, grs_d;

    // An empty output stage always accepts, so bubbles get squeezed out.
    logic en;
    assign en        = out_ready | ~valid2_q;
    assign in_ready  = en;
    assign out_valid = valid2_q;
    assign b         = b_q;
    assign grs       = grs_q;

    // ---------------- stage 1: shifts by 16 and 8 ----------------
    logic [4:0]        shamt;
    logic              sat;
    logic [WORK_W-1:0] w0, w16, w8;
    logic              st16, st8;

    assign shamt = clamp_shift(sa);
    assign sat   = (shamt == 5'(SHIFT_SAT));
    assign w0    = {a, 3'b000};

    shift_stage_sticky #(.SHIFT(16)) u_sh16 (
        .din_i(w0), .en_i(shamt[4]), .dout_o(w16), .sticky_o(st16)
    );
    shift_stage_sticky #(.SHIFT(8)) u_sh8 (
        .din_i(w16), .en_i(shamt[3]), .dout_o(w8), .sticky_o(st8)
    );

    always_comb begin
        s1_d.w      = sat ? '0 : w8;
        s1_d.sticky = sat ? (|a) : (st16 | st8);
        s1_d.s_lo   = shamt[2:0];
        s1_d.sat    = sat;
    end

    // ---------------- stage 2: shifts by 4, 2 and 1 ----------------
    logic [WORK_W-1:0] w4, w2, w1, r;
    logic              st4, st2, st1, sticky;

    shift_stage_sticky #(.SHIFT(4)) u_sh4 (
        .din_i(s1_q.w), .en_i(s1_q.s_lo[2]), .dout_o(w4), .sticky_o(st4)
    );
    shift_stage_sticky #(.SHIFT(2)) u_sh2 (
        .din_i(w4), .en_i(s1_q.s_lo[1]), .dout_o(w2), .sticky_o(st2)
    );
    shift_stage_sticky #(.SHIFT(1)) u_sh1 (
        .din_i(w2), .en_i(s1_q.s_lo[0]), .dout_o(w1), .sticky_o(st1)
    );

    always_comb begin
        r      = s1_q.sat ? '0 : w1;
        sticky = s1_q.sticky | (~s1_q.sat & (st4 | st2 | st1));
        b_d    = r[WORK_W-1:GRS_W];
        grs_d  = {r[2], r[1], r[0] | sticky};
    end

    // NOTE: nonblocking assignments so both stages sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1_q <= 1'b0;
            s1_q     <= '0;
            valid2_q <= 1'b0;
            b_q      <= '0;
            grs_q    <= '0;
        end else if (en) begin
            valid1_q <= in_valid;
            valid2_q <= valid1_q;
            // Data only moves with a valid token; bubbles leave last values.
            if (in_valid) s1_q <= s1_d;
            if (valid1_q) begin
                b_q   <= b_d;
                grs_q <= grs_d;
            end
        end
    end

endmodule
